mem_dcache_req_ctrl: RTL and testbench
======================================

// Module: mem_dcache_req_ctrl
// PURPOSE
//  - MEM-stage initiator towards the DCache. Takes one load/store per instruction,
//    issues a valid/addr_ok request, then waits for data_ok.
//  - Sign/zero-extends load data; builds the store byte-strobe and replicated write data.
//  - Drives the MEM-stage stall/done signals that the pipeline stall/flush control consumes.
//  - Sits between the EX/MEM register and the DCache request port.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  32  data width (fixed 32; sub-word logic assumes 4 bytes)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       reset, asynchronous, active-low
//  mem_valid    in   1       MEM stage holds a memory instruction
//  mem_we       in   1       1=store, 0=load
//  mem_size     in   2       0=byte 1=half 2=word (3 illegal, treated as word)
//  mem_unsigned in   1       load zero-extend (ld.bu/ld.hu)
//  mem_addr     in   ADDR_W  byte address
//  mem_wdata    in   DATA_W  store data, low-aligned
//  flush        in   1       pipeline flush (exception/ertn), kills in-flight op
//  wb_allowin   in   1       WB stage accepts result this cycle
//  dc_valid     out  1       request valid to DCache
//  dc_op        out  1       1=write
//  dc_addr      out  ADDR_W  request address (latched)
//  dc_wstrb     out  4       byte enables (0 for loads)
//  dc_wdata     out  DATA_W  lane-replicated store data
//  dc_addr_ok   in   1       DCache accepted request
//  dc_data_ok   in   1       DCache response (loads and stores)
//  dc_rdata     in   DATA_W  raw load word
//  mem_rdata    out  DATA_W  extended load result (held in DONE)
//  mem_stall    out  1       stall MEM and earlier stages
//  mem_done     out  1       op complete, result valid
//  mem_ale      out  1       misaligned-address exception (CFG-dependent)
// BEHAVIOUR
//  - Reset: state=IDLE; dc_valid, dc_op, mem_stall, mem_done, mem_ale = 0;
//    dc_addr, dc_wstrb, dc_wdata, mem_rdata = 0.
//  - FSM: IDLE, REQ, WAIT, DONE, CANCEL. All outputs are decoded from registered state.
//  - IDLE: if mem_valid && !flush, latch op/addr/size/strb/wdata and go to REQ.
//    dc_valid rises exactly 1 cycle after mem_valid is first seen.
//  - REQ: dc_valid=1; request fields stay stable until dc_addr_ok.
//    - addr_ok && !flush -> WAIT.
//    - flush && !addr_ok -> IDLE (the only legal valid-drop without ready).
//    - flush && addr_ok -> CANCEL.
//  - WAIT: dc_valid=0.
//    - data_ok -> capture extended rdata (loads), go to DONE.
//    - flush && !data_ok -> CANCEL; flush && data_ok -> IDLE, data discarded.
//  - DONE: mem_done=1.
//    - wb_allowin -> IDLE.
//    - flush -> IDLE.
//  - CANCEL: wait for data_ok, discard it, go to IDLE. No new request is issued while in CANCEL.
//  - mem_stall: 1 when mem_valid is high and state is not DONE; in DONE, mem_stall = !wb_allowin;
//    in CANCEL, mem_stall = 1.
//  - Min load/store latency: mem_valid -> mem_done is 3 cycles with addr_ok and data_ok on first opportunity.
//  - Store strobe: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'hF.
//    wdata: byte replicated x4, half replicated x2.
//  - Load extract: byte lane = addr[1:0], half lane = addr[1].
//    Sign-extend unless mem_unsigned; word passes through.
//  - data_ok while in IDLE/REQ/DONE is a protocol violation; it is ignored.
// CONFIGURATION
//  - MEM_ALIGN_CHECK_EN defined:
//    - Misaligned access raises the exception instead of issuing a request:
//      half with addr[0]=1, or word with addr[1:0]!=0.
//    - On a misaligned IDLE->accept, skip REQ and go to DONE with mem_ale=1 and mem_rdata=0.
//    - mem_ale clears on leaving DONE.
//  - MEM_ALIGN_CHECK_EN undefined:
//    - mem_ale tied to 0; low address bits are ignored for lane select
//      (half uses addr[1], word uses none).
// TESTING
//  1. ld.b addr=0x1003, rdata=0x80FF_FF00, addr_ok/data_ok immediate
//     -> dc_wstrb=0, mem_rdata=0xFFFF_FF80, mem_done at cycle 3.
//  2. st.h addr=0x2002, wdata=0x0000_BEEF -> dc_wstrb=4'b1100,
//     dc_wdata=0xBEEF_BEEF, dc_op=1; addr_ok held low 4 cycles
//     -> dc_valid stays 1 and fields stay stable.
//  3. flush 1 cycle after addr_ok, data_ok 3 cycles later
//     -> CANCEL, mem_done never asserted, mem_stall=1 until data_ok, then IDLE.
//  4. ld.hu addr=0x10 completes with wb_allowin=0 for 2 cycles
//     -> mem_done held, mem_rdata stable, mem_stall=1 until wb_allowin.
//  5. rst asserted mid-WAIT -> all outputs 0 immediately (async), state IDLE after release.
//  6. MEM_ALIGN_CHECK_EN: ld.w addr=0x6 -> no dc_valid, mem_ale=1 + mem_done 1 cycle after accept;
//     without the macro -> normal request to 0x6.

Source files
------------

// File: rtl/mem_dcache_req_ctrl_if.sv
// MEM-stage <-> DCache request bundle: pipeline-side op/control plus the
// valid/addr_ok/data_ok request port. master = controller, slave = environment.
interface mem_dcache_req_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_valid;
   logic              mem_we;
   logic [1:0]        mem_size;
   logic              mem_unsigned;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              flush;
   logic              wb_allowin;
   logic              dc_valid;
   logic              dc_op;
   logic [ADDR_W-1:0] dc_addr;
   logic [3:0]        dc_wstrb;
   logic [DATA_W-1:0] dc_wdata;
   logic              dc_addr_ok;
   logic              dc_data_ok;
   logic [DATA_W-1:0] dc_rdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_stall;
   logic              mem_done;
   logic              mem_ale;

   modport master (
      input  mem_valid, mem_we, mem_size, mem_unsigned, mem_addr, mem_wdata,
             flush, wb_allowin, dc_addr_ok, dc_data_ok, dc_rdata,
      output dc_valid, dc_op, dc_addr, dc_wstrb, dc_wdata,
             mem_rdata, mem_stall, mem_done, mem_ale
   );

   modport slave (
      output mem_valid, mem_we, mem_size, mem_unsigned, mem_addr, mem_wdata,
             flush, wb_allowin, dc_addr_ok, dc_data_ok, dc_rdata,
      input  dc_valid, dc_op, dc_addr, dc_wstrb, dc_wdata,
             mem_rdata, mem_stall, mem_done, mem_ale
   );
endinterface

// File: rtl/mem_dcache_req_ctrl.sv
// MEM-stage DCache initiator: one request per memory op, waits for data_ok, extends loads.
// MEM_ALIGN_CHECK_EN enables misaligned-address exception (mem_ale) instead of a request.
module mem_dcache_req_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   mem_dcache_req_ctrl_if.master  io_bus
);
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} st_t;

   st_t               r_state, w_next;
   logic              r_we, r_uns, r_ale;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        r_wstrb;
   logic [DATA_W-1:0] r_wdata, r_rdata;

   logic              w_accept, w_mis;
   logic [3:0]        w_strb;
   logic [DATA_W-1:0] w_wrep, w_ext;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;

   assign w_accept = (r_state == S_IDLE) && io_bus.mem_valid && !io_bus.flush;

`ifdef MEM_ALIGN_CHECK_EN
   assign w_mis = ((io_bus.mem_size == 2'd1) && io_bus.mem_addr[0]) ||
                  (io_bus.mem_size[1] && (io_bus.mem_addr[1:0] != 2'b00));
`else
   assign w_mis = 1'b0;
`endif

   // store strobe and lane replication; size 3 falls through as word
   always_comb begin
      w_strb = 4'hF;
      w_wrep = io_bus.mem_wdata;
      case (io_bus.mem_size)
         2'd0: begin
            w_strb = 4'b0001 << io_bus.mem_addr[1:0];
            w_wrep = {4{io_bus.mem_wdata[7:0]}};
         end
         2'd1: begin
            w_strb = 4'b0011 << {io_bus.mem_addr[1], 1'b0};
            w_wrep = {2{io_bus.mem_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // load lane extract uses the latched address, not the live pipeline input
   always_comb begin
      w_byte = io_bus.dc_rdata[8*r_addr[1:0] +: 8];
      w_half = r_addr[1] ? io_bus.dc_rdata[31:16] : io_bus.dc_rdata[15:0];
      w_ext  = io_bus.dc_rdata;
      case (r_size)
         2'd0:    w_ext = {{24{!r_uns && w_byte[7]}}, w_byte};
         2'd1:    w_ext = {{16{!r_uns && w_half[15]}}, w_half};
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next             = r_state;
      io_bus.dc_valid    = (r_state == S_REQ);
      io_bus.mem_done    = (r_state == S_DONE);
      io_bus.mem_stall   = 1'b0;
      case (r_state)
         S_IDLE:   if (w_accept) w_next = w_mis ? S_DONE : S_REQ;
         S_REQ: begin
            if (io_bus.flush)           w_next = io_bus.dc_addr_ok ? S_CANCEL : S_IDLE;
            else if (io_bus.dc_addr_ok) w_next = S_WAIT;
         end
         S_WAIT: begin
            if (io_bus.dc_data_ok) w_next = io_bus.flush ? S_IDLE : S_DONE;
            else if (io_bus.flush) w_next = S_CANCEL;
         end
         S_DONE:   if (io_bus.wb_allowin || io_bus.flush) w_next = S_IDLE;
         S_CANCEL: if (io_bus.dc_data_ok) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      case (r_state)
         S_DONE:   io_bus.mem_stall = i_rst && !io_bus.wb_allowin;
         S_CANCEL: io_bus.mem_stall = i_rst;
         default:  io_bus.mem_stall = i_rst && io_bus.mem_valid;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_we    <= 1'b0;
         r_uns   <= 1'b0;
         r_size  <= 2'd0;
         r_addr  <= '0;
         r_wstrb <= 4'h0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_ale   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we    <= io_bus.mem_we;
            r_uns   <= io_bus.mem_unsigned;
            r_size  <= io_bus.mem_size;
            r_addr  <= io_bus.mem_addr;
            r_wstrb <= io_bus.mem_we ? w_strb : 4'h0;
            r_wdata <= w_wrep;
         end
         if (w_accept && w_mis)
            r_rdata <= '0;
         else if ((r_state == S_WAIT) && io_bus.dc_data_ok && !io_bus.flush)
            r_rdata <= r_we ? '0 : w_ext;
         if (w_accept)
            r_ale <= w_mis;
         else if ((r_state == S_DONE) && (w_next != S_DONE))
            r_ale <= 1'b0;
      end
   end

   assign io_bus.dc_op     = r_we;
   assign io_bus.dc_addr   = r_addr;
   assign io_bus.dc_wstrb  = r_wstrb;
   assign io_bus.dc_wdata  = r_wdata;
   assign io_bus.mem_rdata = r_rdata;
`ifdef MEM_ALIGN_CHECK_EN
   assign io_bus.mem_ale   = r_ale;
`else
   assign io_bus.mem_ale   = 1'b0;
`endif
endmodule

// File: tb/tb_mem_dcache_req_ctrl.sv
// Directed bench for mem_dcache_req_ctrl: loads/stores, backpressure, flush/cancel, reset.
module tb_mem_dcache_req_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_dcache_req_ctrl_if #(.ADDR_W(32), .DATA_W(32)) dif ();

  mem_dcache_req_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(dif)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // full transaction with addr_ok/data_ok on first opportunity
  task automatic run_op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input logic [3:0] e_strb, input logic [31:0] e_wd, input logic [31:0] e_rd);
    dif.mem_valid = 1'b1; dif.mem_we = we; dif.mem_size = sz; dif.mem_unsigned = uns;
    dif.mem_addr = a; dif.mem_wdata = wd; dif.dc_rdata = rd;
    dif.dc_addr_ok = 1'b1; dif.dc_data_ok = 1'b1; dif.wb_allowin = 1'b1;
    tick();
    chk({tag, ".c1_valid"}, dif.dc_valid, 1);
    chk({tag, ".c1_op"},    dif.dc_op, we);
    chk({tag, ".c1_addr"},  dif.dc_addr, a);
    chk({tag, ".c1_strb"},  dif.dc_wstrb, e_strb);
    chk({tag, ".c1_wdata"}, dif.dc_wdata, e_wd);
    chk({tag, ".c1_stall"}, dif.mem_stall, 1);
    tick();
    chk({tag, ".c2_valid"}, dif.dc_valid, 0);
    chk({tag, ".c2_done"},  dif.mem_done, 0);
    tick();
    chk({tag, ".c3_done"},  dif.mem_done, 1);
    chk({tag, ".c3_rdata"}, dif.mem_rdata, e_rd);
    chk({tag, ".c3_stall"}, dif.mem_stall, 0);
    dif.mem_valid = 1'b0; dif.dc_addr_ok = 1'b0; dif.dc_data_ok = 1'b0;
    tick();
    chk({tag, ".c4_done"},  dif.mem_done, 0);
  endtask

  initial begin
    dif.mem_valid = 0; dif.mem_we = 0; dif.mem_size = 0; dif.mem_unsigned = 0;
    dif.mem_addr = 0; dif.mem_wdata = 0; dif.flush = 0; dif.wb_allowin = 1;
    dif.dc_addr_ok = 0; dif.dc_data_ok = 0; dif.dc_rdata = 0;

    tick(); tick();
    chk("rst.valid", dif.dc_valid, 0);
    chk("rst.stall", dif.mem_stall, 0);
    chk("rst.done",  dif.mem_done, 0);
    chk("rst.addr",  dif.dc_addr, 0);
    chk("rst.rdata", dif.mem_rdata, 0);
    chk("rst.ale",   dif.mem_ale, 0);
    rst = 1'b1;
    tick();
    chk("idle.valid", dif.dc_valid, 0);

    // sub-word vectors
    run_op("ldb",  0, 2'd0, 0, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 4'h0, 32'h0, 32'hFFFF_FF80);
    run_op("ldbu", 0, 2'd0, 1, 32'h0000_1001, 32'h0, 32'h1234_F600, 4'h0, 32'h0, 32'h0000_00F6);
    run_op("ldh",  0, 2'd1, 0, 32'h0000_0002, 32'h0, 32'h8001_0000, 4'h0, 32'h0, 32'hFFFF_8001);
    run_op("stb",  1, 2'd0, 0, 32'h0000_0101, 32'h0000_005A, 32'h0, 4'b0010, 32'h5A5A_5A5A, 32'h0);
    run_op("stw",  1, 2'd2, 0, 32'h0000_0200, 32'h1122_3344, 32'h0, 4'hF, 32'h1122_3344, 32'h0);

    // st.h with addr_ok held off: request must stay stable
    dif.mem_valid = 1; dif.mem_we = 1; dif.mem_size = 2'd1; dif.mem_unsigned = 0;
    dif.mem_addr = 32'h2002; dif.mem_wdata = 32'h0000_BEEF;
    tick();
    dif.mem_addr = 32'h0; dif.mem_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      chk("sth.hold_valid", dif.dc_valid, 1);
      chk("sth.hold_addr",  dif.dc_addr, 32'h2002);
      chk("sth.hold_strb",  dif.dc_wstrb, 4'b1100);
      chk("sth.hold_wdata", dif.dc_wdata, 32'hBEEF_BEEF);
      chk("sth.hold_op",    dif.dc_op, 1);
      tick();
    end
    chk("sth.still_valid", dif.dc_valid, 1);
    dif.dc_addr_ok = 1;
    tick();
    chk("sth.wait_valid", dif.dc_valid, 0);
    dif.dc_addr_ok = 0; dif.dc_data_ok = 1;
    tick();
    chk("sth.done", dif.mem_done, 1);
    dif.mem_valid = 0; dif.dc_data_ok = 0;
    tick();
    chk("sth.idle", dif.mem_done, 0);

    // flush one cycle after addr_ok -> CANCEL until data_ok
    dif.mem_valid = 1; dif.mem_we = 0; dif.mem_size = 2'd2; dif.mem_addr = 32'h3000;
    dif.dc_addr_ok = 1;
    tick();
    tick();
    dif.dc_addr_ok = 0; dif.flush = 1; dif.mem_valid = 0;
    tick();
    dif.flush = 0;
    for (int i = 0; i < 3; i++) begin
      chk("cancel.stall", dif.mem_stall, 1);
      chk("cancel.done",  dif.mem_done, 0);
      chk("cancel.valid", dif.dc_valid, 0);
      if (i == 2) dif.dc_data_ok = 1;
      tick();
    end
    chk("cancel.exit_stall", dif.mem_stall, 0);
    chk("cancel.exit_done",  dif.mem_done, 0);
    dif.dc_data_ok = 0;

    // flush in REQ without addr_ok drops the request
    dif.mem_valid = 1; dif.mem_addr = 32'h3100;
    tick();
    chk("reqflush.valid0", dif.dc_valid, 1);
    dif.flush = 1; dif.mem_valid = 0;
    tick();
    dif.flush = 0;
    chk("reqflush.valid1", dif.dc_valid, 0);
    chk("reqflush.stall",  dif.mem_stall, 0);

    // ld.hu with WB backpressure
    dif.mem_valid = 1; dif.mem_we = 0; dif.mem_size = 2'd1; dif.mem_unsigned = 1;
    dif.mem_addr = 32'h10; dif.dc_rdata = 32'h1234_8765;
    dif.dc_addr_ok = 1; dif.dc_data_ok = 1; dif.wb_allowin = 0;
    tick(); tick(); tick();
    dif.dc_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      chk("ldhu.done",  dif.mem_done, 1);
      chk("ldhu.rdata", dif.mem_rdata, 32'h0000_8765);
      chk("ldhu.stall", dif.mem_stall, 1);
      tick();
    end
    dif.wb_allowin = 1;
    #1;
    chk("ldhu.release_stall", dif.mem_stall, 0);
    dif.mem_valid = 0; dif.dc_addr_ok = 0; dif.dc_data_ok = 0;
    tick();
    chk("ldhu.idle", dif.mem_done, 0);

    // async reset mid-WAIT
    dif.mem_valid = 1; dif.mem_size = 2'd2; dif.mem_unsigned = 0; dif.mem_addr = 32'h40;
    dif.dc_addr_ok = 1;
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("arst.valid", dif.dc_valid, 0);
    chk("arst.addr",  dif.dc_addr, 0);
    chk("arst.stall", dif.mem_stall, 0);
    chk("arst.rdata", dif.mem_rdata, 0);
    chk("arst.done",  dif.mem_done, 0);
    dif.mem_valid = 0; dif.dc_addr_ok = 0;
    tick();
    rst = 1'b1;
    tick();
    chk("arst.post_valid", dif.dc_valid, 0);
    chk("arst.post_done",  dif.mem_done, 0);

    // ld.w to misaligned 0x6
    dif.mem_valid = 1; dif.mem_we = 0; dif.mem_size = 2'd2; dif.mem_addr = 32'h6;
    dif.dc_rdata = 32'hCAFE_F00D; dif.dc_addr_ok = 1; dif.dc_data_ok = 1;
    tick();
`ifdef MEM_ALIGN_CHECK_EN
    chk("ale.valid", dif.dc_valid, 0);
    chk("ale.done",  dif.mem_done, 1);
    chk("ale.flag",  dif.mem_ale, 1);
    chk("ale.rdata", dif.mem_rdata, 0);
    dif.mem_valid = 0;
    tick();
    chk("ale.clear", dif.mem_ale, 0);
    chk("ale.idle",  dif.mem_done, 0);
`else
    chk("mis.valid", dif.dc_valid, 1);
    chk("mis.addr",  dif.dc_addr, 32'h6);
    chk("mis.ale",   dif.mem_ale, 0);
    tick(); tick();
    chk("mis.done",  dif.mem_done, 1);
    chk("mis.rdata", dif.mem_rdata, 32'hCAFE_F00D);
    dif.mem_valid = 0;
    tick();
    chk("mis.idle",  dif.mem_done, 0);
`endif
    dif.dc_addr_ok = 0; dif.dc_data_ok = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
